sample_msg_combiner: RTL and testbench
======================================

SAMPLE_MSG_COMBINER -- requirements
Module: sample_msg_combiner

Interface
REQ-001: Parameter WIDTH, default 32, word width of all data ports.
REQ-002: Parameter SAMPLE_DEPTH, default 64, sample buffer depth in words; power of two, at least 2.
REQ-003: Parameter MSG_DEPTH, default 64, message buffer depth in words; power of two, at least 2.
REQ-004: Port clk, input, 1 bit, single clock; all logic on its rising edge.
REQ-005: Port rst, input, 1 bit, reset; synchronous and active-high.
REQ-006: Port in_samples, input, WIDTH bits, sample word; MSB expected 0.
REQ-007: Port in_samples_nd, input, 1 bit, in_samples valid this cycle.
REQ-008: Port in_msg, input, WIDTH bits, message word. Header has MSB=1 and length in bits [WIDTH-2 -: MSG_LENGTH_WIDTH]. Contents have MSB=0.
REQ-009: Port in_msg_nd, input, 1 bit, in_msg valid this cycle.
REQ-010: Port out_data, output, WIDTH bits, merged stream word.
REQ-011: Port out_nd, output, 1 bit, out_data valid this cycle.
REQ-012: Port error, output, 1 bit, sticky fault flag.

Function
REQ-013: Block merges the sample and message streams into one stream that sample_msg_splitter can parse; no backpressure exists anywhere.
REQ-014: Sample path: each valid sample is written to the sample FIFO; if the FIFO is full, the sample is dropped and error is set.
REQ-015: Message writer FSM W_IDLE:
- Header with length L and free space >= L+1: write the header; go to W_BODY with remaining=L, or stay in W_IDLE if L=0.
- Header with insufficient space: drop it, set error, go to W_DROP with remaining=L.
REQ-016: W_BODY: each valid content word is written and remaining is decremented; at remaining=1 the message is complete and the FSM returns to W_IDLE.
REQ-017: W_DROP: content words are discarded with the same counting as W_BODY; the FSM returns to W_IDLE on the last one.
REQ-018: Ordering faults:
- Content word in W_IDLE: dropped, error set.
- Header in W_BODY or W_DROP: dropped, error set, state unchanged.
REQ-019: complete_count is incremented when a message finishes writing (including an L=0 header). It is decremented when the reader starts a message. Simultaneous increment and decrement leaves it unchanged.
REQ-020: Reader FSM R_IDLE:
- complete_count>0: emit the header and go to R_MSG with remaining=L (stay in R_IDLE if L=0).
- Otherwise, sample FIFO non-empty: emit one sample.
- Otherwise: out_nd=0.
REQ-021: If a message and a sample are both ready, the message wins; a sample is never emitted between a header and its last content word.
REQ-022: R_MSG: one content word is emitted per cycle, with out_nd held high, until remaining reaches 0; then the FSM returns to R_IDLE.
REQ-023: out_data and out_nd are registered; at most one word is emitted per cycle.
REQ-024: Latency: a word written with nd in cycle c into an idle block appears with out_nd=1 in cycle c+2.
REQ-025: Same-cycle in_samples_nd and in_msg_nd are both accepted.
REQ-026: FIFO read and write in the same cycle are both legal, including when the FIFO is full.
REQ-027: error stays set until rst.

Reset
REQ-028: While rst is high at a clock edge, the block SHALL:
- drive out_nd=0, out_data=0 and error=0;
- empty both FIFOs and clear complete_count;
- put both FSMs in their IDLE states with remaining=0.
REQ-029: Reset mid-message discards all buffered partial and complete data; the first word after reset is parsed as if in W_IDLE.

Configuration
REQ-030: With SAMPLE_MSG_COMBINER_MSB_CHECK_EN defined, a sample with MSB=1 is dropped and error is set.
REQ-031: Without SAMPLE_MSG_COMBINER_MSB_CHECK_EN, samples are forwarded unchecked, and error reflects only overflow and ordering faults.

Structure
REQ-032: Package msg_pkg holds MSG_LENGTH_WIDTH (=10), the header-bit index, the length-field extraction function, and the writer and reader state enumerations.
REQ-033: One sub-module, sync_fifo (parameters WIDTH and DEPTH; outputs full, empty and free count), is instantiated twice: once for samples and once for messages.

Verification
REQ-034: Samples 0x1,0x2,0x3 on consecutive cycles with no messages -> out_data 0x1,0x2,0x3 in cycles c+2..c+4, error=0.
REQ-035: Header 0x80400000 (L=2), contents 0xA,0xB, with a sample 0x5 arriving concurrently -> header,0xA,0xB contiguous on out_data and 0x5 emitted after them.
REQ-036: Two header-only L=0 messages and 3 samples arriving together -> both headers are emitted before any sample, and all 5 words appear.
REQ-037: MSG_DEPTH=4 with a header of L=5 -> the header and 5 contents are dropped, error=1, and a following L=1 message passes intact.
REQ-038: Content 0x7 with no header, then a header in W_BODY -> both are dropped, and error=1 until rst; rst mid-message -> out_nd=0, error=0, and the next L=1 message passes.
REQ-039: Sample 0x80000001 -> dropped with error=1 when SAMPLE_MSG_COMBINER_MSB_CHECK_EN is defined; passed unchanged with error=0 when it is not.

Source files
------------

// File: rtl/msg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msg_pkg
// Purpose  : Shared message-format constants, header decode helpers and FSM
//            state encodings for the sample/message combiner.
// Revision : 1.0
// ============================================================================
package msg_pkg;

   localparam int MSG_LENGTH_WIDTH = 10;
   localparam int MSG_MAX_WIDTH    = 64;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_BODY = 2'd1,
      W_DROP = 2'd2
   } wr_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_MSG  = 1'b1
   } rd_state_t;

   // Header flag is the word MSB.
   function automatic int msg_hdr_bit(input int width);
      return width - 1;
   endfunction

   // Length field sits directly below the header flag.
   function automatic logic [MSG_LENGTH_WIDTH-1:0] msg_length(
      input logic [MSG_MAX_WIDTH-1:0] word,
      input int                       width
   );
      return MSG_LENGTH_WIDTH'(word >> (width - 1 - MSG_LENGTH_WIDTH));
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock show-ahead FIFO; a write while full is accepted
//            only when a read frees a slot in the same cycle.
// Revision : 1.0
// ============================================================================
module sync_fifo
   import msg_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   free_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_wr, do_rd;

   always_comb begin
      do_rd    = rd_en && (count_q != '0);
      do_wr    = wr_en && ((count_q != CW'(DEPTH)) || do_rd);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q + CW'(do_wr) - CW'(do_rd);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data    = mem_q[rd_ptr_q];
   assign full       = (count_q == CW'(DEPTH));
   assign empty      = (count_q == '0);
   assign free_count = CW'(DEPTH) - count_q;

endmodule
`default_nettype wire

// File: rtl/sample_msg_combiner.sv
`default_nettype none
// ============================================================================
// Module   : sample_msg_combiner
// Purpose  : Merges a sample stream and a framed message stream into one
//            output stream; whole messages take priority over samples.
// Options  : SAMPLE_MSG_COMBINER_MSB_CHECK_EN drops samples with MSB set.
// Revision : 1.0
// ============================================================================
module sample_msg_combiner
   import msg_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int SAMPLE_DEPTH = 64,
   parameter int MSG_DEPTH    = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_samples,
   input  logic             in_samples_nd,
   input  logic [WIDTH-1:0] in_msg,
   input  logic             in_msg_nd,
   output logic [WIDTH-1:0] out_data,
   output logic             out_nd,
   output logic             error
);

   localparam int HDR_BIT = msg_hdr_bit(WIDTH);
   localparam int SCW     = $clog2(SAMPLE_DEPTH) + 1;
   localparam int MCW     = $clog2(MSG_DEPTH) + 1;
   localparam int LW      = MSG_LENGTH_WIDTH;

   logic             s_wr, s_rd, s_full, s_empty;
   logic [WIDTH-1:0] s_rd_data;
   logic [SCW-1:0]   s_free;
   logic             m_wr, m_rd, m_full, m_empty;
   logic [WIDTH-1:0] m_rd_data;
   logic [MCW-1:0]   m_free;

   wr_state_t        wr_state_q, wr_state_d;
   logic [LW-1:0]    wr_rem_q, wr_rem_d;
   rd_state_t        rd_state_q, rd_state_d;
   logic [LW-1:0]    rd_rem_q, rd_rem_d;
   logic [MCW-1:0]   complete_count_q, complete_count_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_nd_q, out_nd_d;
   logic             error_q, error_d;

   logic             in_is_hdr;
   logic [LW-1:0]    in_len;
   logic [LW-1:0]    head_len;
   logic             s_bad, s_fault, m_fault;
   logic             msg_done, msg_start;
   logic             unused_fifo_status;

   assign unused_fifo_status = ^{s_free, m_full, m_empty};

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (SAMPLE_DEPTH)
   ) u_sample_fifo (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (s_wr),
      .wr_data    (in_samples),
      .rd_en      (s_rd),
      .rd_data    (s_rd_data),
      .full       (s_full),
      .empty      (s_empty),
      .free_count (s_free)
   );

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (MSG_DEPTH)
   ) u_msg_fifo (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (m_wr),
      .wr_data    (in_msg),
      .rd_en      (m_rd),
      .rd_data    (m_rd_data),
      .full       (m_full),
      .empty      (m_empty),
      .free_count (m_free)
   );

   // Sample path: a slot freed by this cycle's read may be reused at once.
   always_comb begin
`ifdef SAMPLE_MSG_COMBINER_MSB_CHECK_EN
      s_bad   = in_samples[WIDTH-1];
`else
      s_bad   = 1'b0;
`endif
      s_wr    = in_samples_nd && !s_bad && (!s_full || s_rd);
      s_fault = in_samples_nd && !s_wr;
   end

   // Message writer: space for the whole message is reserved at the header,
   // so body words never need a fullness check.
   always_comb begin
      in_is_hdr  = in_msg[HDR_BIT];
      in_len     = msg_length(MSG_MAX_WIDTH'(in_msg), WIDTH);
      wr_state_d = wr_state_q;
      wr_rem_d   = wr_rem_q;
      m_wr       = 1'b0;
      msg_done   = 1'b0;
      m_fault    = 1'b0;
      if (in_msg_nd) begin
         case (wr_state_q)
            W_IDLE: begin
               if (!in_is_hdr) begin
                  m_fault = 1'b1;
               end else if (32'(m_free) >= (32'(in_len) + 32'd1)) begin
                  m_wr = 1'b1;
                  if (in_len == '0) begin
                     msg_done = 1'b1;
                  end else begin
                     wr_state_d = W_BODY;
                     wr_rem_d   = in_len;
                  end
               end else begin
                  m_fault = 1'b1;
                  if (in_len != '0) begin
                     wr_state_d = W_DROP;
                     wr_rem_d   = in_len;
                  end
               end
            end
            W_BODY, W_DROP: begin
               if (in_is_hdr) begin
                  m_fault = 1'b1;
               end else begin
                  m_wr     = (wr_state_q == W_BODY);
                  wr_rem_d = wr_rem_q - LW'(1);
                  if (wr_rem_q == LW'(1)) begin
                     msg_done   = (wr_state_q == W_BODY);
                     wr_state_d = W_IDLE;
                  end
               end
            end
            default: begin
               wr_state_d = W_IDLE;
               wr_rem_d   = '0;
            end
         endcase
      end
   end

   // Reader: only fully buffered messages are started, so body words are
   // always present once a header has been emitted.
   always_comb begin
      head_len   = msg_length(MSG_MAX_WIDTH'(m_rd_data), WIDTH);
      rd_state_d = rd_state_q;
      rd_rem_d   = rd_rem_q;
      s_rd       = 1'b0;
      m_rd       = 1'b0;
      msg_start  = 1'b0;
      out_nd_d   = 1'b0;
      out_data_d = '0;
      case (rd_state_q)
         R_IDLE: begin
            if (complete_count_q != '0) begin
               m_rd       = 1'b1;
               msg_start  = 1'b1;
               out_nd_d   = 1'b1;
               out_data_d = m_rd_data;
               if (head_len != '0) begin
                  rd_state_d = R_MSG;
                  rd_rem_d   = head_len;
               end
            end else if (!s_empty) begin
               s_rd       = 1'b1;
               out_nd_d   = 1'b1;
               out_data_d = s_rd_data;
            end
         end
         R_MSG: begin
            m_rd       = 1'b1;
            out_nd_d   = 1'b1;
            out_data_d = m_rd_data;
            rd_rem_d   = rd_rem_q - LW'(1);
            if (rd_rem_q == LW'(1)) rd_state_d = R_IDLE;
         end
         default: begin
            rd_state_d = R_IDLE;
            rd_rem_d   = '0;
         end
      endcase
   end

   always_comb begin
      complete_count_d = complete_count_q + MCW'(msg_done) - MCW'(msg_start);
      error_d          = error_q | s_fault | m_fault;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q       <= W_IDLE;
         wr_rem_q         <= '0;
         rd_state_q       <= R_IDLE;
         rd_rem_q         <= '0;
         complete_count_q <= '0;
         out_data_q       <= '0;
         out_nd_q         <= 1'b0;
         error_q          <= 1'b0;
      end else begin
         wr_state_q       <= wr_state_d;
         wr_rem_q         <= wr_rem_d;
         rd_state_q       <= rd_state_d;
         rd_rem_q         <= rd_rem_d;
         complete_count_q <= complete_count_d;
         out_data_q       <= out_data_d;
         out_nd_q         <= out_nd_d;
         error_q          <= error_d;
      end
   end

   assign out_data = out_data_q;
   assign out_nd   = out_nd_q;
   assign error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_msg_combiner.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_msg_combiner
// Purpose  : Directed per-cycle vector table plus a sample-overflow sequence.
// Revision : 1.0
// ============================================================================
module tb_sample_msg_combiner;

`ifdef SAMPLE_MSG_COMBINER_MSB_CHECK_EN
   localparam logic MSB_CHK = 1'b1;
`else
   localparam logic MSB_CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_samples;
   logic        in_samples_nd;
   logic [31:0] in_msg;
   logic        in_msg_nd;
   logic [31:0] out_data;
   logic        out_nd;
   logic        error;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic        s_nd;
      logic [31:0] s;
      logic        m_nd;
      logic [31:0] m;
      logic        e_nd;
      logic [31:0] e_data;
      logic        e_err;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] got[$];
   logic [31:0] want[$];

   always #5 clk = ~clk;

   sample_msg_combiner #(
      .WIDTH        (32),
      .SAMPLE_DEPTH (4),
      .MSG_DEPTH    (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_samples    (in_samples),
      .in_samples_nd (in_samples_nd),
      .in_msg        (in_msg),
      .in_msg_nd     (in_msg_nd),
      .out_data      (out_data),
      .out_nd        (out_nd),
      .error         (error)
   );

   task automatic add(input logic r, input logic snd, input logic [31:0] s,
                      input logic mnd, input logic [31:0] m,
                      input logic end_, input logic [31:0] ed, input logic ee);
      vec_t v;
      v.rst = r; v.s_nd = snd; v.s = s; v.m_nd = mnd; v.m = m;
      v.e_nd = end_; v.e_data = ed; v.e_err = ee;
      vecs.push_back(v);
   endtask

   task automatic idle(input logic end_, input logic [31:0] ed, input logic ee);
      add(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, end_, ed, ee);
   endtask

   // One clock: drive inputs, then sample outputs 1 time unit after the edge.
   task automatic step(input logic r, input logic snd, input logic [31:0] s,
                       input logic mnd, input logic [31:0] m);
      rst = r; in_samples_nd = snd; in_samples = s; in_msg_nd = mnd; in_msg = m;
      @(posedge clk);
      #1;
      if (out_nd) got.push_back(out_data);
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0b want %0b", name, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1; in_samples = '0; in_samples_nd = 1'b0; in_msg = '0; in_msg_nd = 1'b0;

      // reset, then three back-to-back samples
      add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      add(1'b0, 1'b1, 32'h1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      add(1'b0, 1'b1, 32'h2, 1'b0, 32'h0, 1'b1, 32'h1, 1'b0);
      add(1'b0, 1'b1, 32'h3, 1'b0, 32'h0, 1'b1, 32'h2, 1'b0);
      idle(1'b1, 32'h3, 1'b0);
      idle(1'b0, 32'h0, 1'b0);
      // L=2 message, sample alongside the last body word loses to the message
      add(1'b0, 1'b0, 32'h0, 1'b1, 32'h80400000, 1'b0, 32'h0, 1'b0);
      add(1'b0, 1'b0, 32'h0, 1'b1, 32'hA, 1'b0, 32'h0, 1'b0);
      add(1'b0, 1'b1, 32'h5, 1'b1, 32'hB, 1'b0, 32'h0, 1'b0);
      idle(1'b1, 32'h80400000, 1'b0);
      idle(1'b1, 32'hA, 1'b0);
      idle(1'b1, 32'hB, 1'b0);
      idle(1'b1, 32'h5, 1'b0);
      idle(1'b0, 32'h0, 1'b0);
      // two L=0 headers with three samples
      add(1'b0, 1'b1, 32'h11, 1'b1, 32'h80000001, 1'b0, 32'h0, 1'b0);
      add(1'b0, 1'b1, 32'h12, 1'b1, 32'h80000002, 1'b1, 32'h80000001, 1'b0);
      add(1'b0, 1'b1, 32'h13, 1'b0, 32'h0, 1'b1, 32'h80000002, 1'b0);
      idle(1'b1, 32'h11, 1'b0);
      idle(1'b1, 32'h12, 1'b0);
      idle(1'b1, 32'h13, 1'b0);
      idle(1'b0, 32'h0, 1'b0);
      // L=5 header cannot fit in a 4-word buffer: header and body dropped
      add(1'b0, 1'b0, 32'h0, 1'b1, 32'h80A00000, 1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 5; k++)
         add(1'b0, 1'b0, 32'h0, 1'b1, 32'h21 + 32'(k), 1'b0, 32'h0, 1'b1);
      add(1'b0, 1'b0, 32'h0, 1'b1, 32'h80200000, 1'b0, 32'h0, 1'b1);
      add(1'b0, 1'b0, 32'h0, 1'b1, 32'h33, 1'b0, 32'h0, 1'b1);
      idle(1'b1, 32'h80200000, 1'b1);
      idle(1'b1, 32'h33, 1'b1);
      idle(1'b0, 32'h0, 1'b1);
      add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      // orphan content word, then a header inside a body
      add(1'b0, 1'b0, 32'h0, 1'b1, 32'h7, 1'b0, 32'h0, 1'b1);
      add(1'b0, 1'b0, 32'h0, 1'b1, 32'h80400000, 1'b0, 32'h0, 1'b1);
      add(1'b0, 1'b0, 32'h0, 1'b1, 32'h41, 1'b0, 32'h0, 1'b1);
      add(1'b0, 1'b0, 32'h0, 1'b1, 32'h80200000, 1'b0, 32'h0, 1'b1);
      add(1'b0, 1'b0, 32'h0, 1'b1, 32'h42, 1'b0, 32'h0, 1'b1);
      idle(1'b1, 32'h80400000, 1'b1);
      idle(1'b1, 32'h41, 1'b1);
      idle(1'b1, 32'h42, 1'b1);
      idle(1'b0, 32'h0, 1'b1);
      // reset in the middle of a message body
      add(1'b0, 1'b0, 32'h0, 1'b1, 32'h80400000, 1'b0, 32'h0, 1'b1);
      add(1'b0, 1'b0, 32'h0, 1'b1, 32'h51, 1'b0, 32'h0, 1'b1);
      add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      add(1'b0, 1'b0, 32'h0, 1'b1, 32'h80200000, 1'b0, 32'h0, 1'b0);
      add(1'b0, 1'b0, 32'h0, 1'b1, 32'h61, 1'b0, 32'h0, 1'b0);
      idle(1'b1, 32'h80200000, 1'b0);
      idle(1'b1, 32'h61, 1'b0);
      idle(1'b0, 32'h0, 1'b0);
      // sample with MSB set
      add(1'b0, 1'b1, 32'h80000001, 1'b0, 32'h0, 1'b0, 32'h0, MSB_CHK);
      idle(!MSB_CHK, 32'h80000001, MSB_CHK);
      idle(1'b0, 32'h0, MSB_CHK);

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst;
         in_samples_nd = vecs[i].s_nd; in_samples = vecs[i].s;
         in_msg_nd = vecs[i].m_nd; in_msg = vecs[i].m;
         @(posedge clk);
         #1;
         checks++;
         if (out_nd !== vecs[i].e_nd) begin
            errors++;
            $display("FAIL row%0d out_nd got %0b want %0b", i, out_nd, vecs[i].e_nd);
         end
         if (vecs[i].e_nd) begin
            checks++;
            if (out_data !== vecs[i].e_data) begin
               errors++;
               $display("FAIL row%0d out_data got %08h want %08h", i, out_data, vecs[i].e_data);
            end
         end
         checks++;
         if (error !== vecs[i].e_err) begin
            errors++;
            $display("FAIL row%0d error got %0b want %0b", i, error, vecs[i].e_err);
         end
      end

      // Sample FIFO overflow while the reader is busy emitting an L=3 message
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      got.delete();
      step(1'b0, 1'b0, 32'h0,  1'b1, 32'h80600000);
      step(1'b0, 1'b0, 32'h0,  1'b1, 32'h71);
      step(1'b0, 1'b0, 32'h0,  1'b1, 32'h72);
      step(1'b0, 1'b1, 32'h91, 1'b1, 32'h73);
      step(1'b0, 1'b1, 32'h92, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h93, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h94, 1'b0, 32'h0);
      check_bit("ovf_err_before", error, 1'b0);
      step(1'b0, 1'b1, 32'h95, 1'b0, 32'h0);
      check_bit("ovf_err_after", error, 1'b1);
      for (int n = 0; n < 20 && got.size() < 8; n++)
         step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      want = '{32'h80600000, 32'h71, 32'h72, 32'h73, 32'h91, 32'h92, 32'h93, 32'h94};
      checks++;
      if (got.size() != want.size()) begin
         errors++;
         $display("FAIL ovf_count got %0d words want %0d", got.size(), want.size());
      end
      for (int j = 0; j < want.size() && j < got.size(); j++) begin
         checks++;
         if (got[j] !== want[j]) begin
            errors++;
            $display("FAIL ovf_word%0d got %08h want %08h", j, got[j], want[j]);
         end
      end
      repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++;
      if (got.size() != want.size()) begin
         errors++;
         $display("FAIL ovf_extra got %0d words want %0d", got.size(), want.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
